// File: rtl/fill_generator.sv
// Exchange-side execution emulator: matches one order at a time against top-of-book
// and emits rate-limited fill slices followed by a completion pulse.
module fill_generator #(
    parameter int unsigned MAX_SLICE    = 100,
    parameter int unsigned MIN_FILL_GAP = 5,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ord_valid,
    output logic        ord_ready,
    input  logic [7:0]  ord_side,
    input  logic [31:0] ord_qty,
    input  logic [31:0] ord_price,
    input  logic [31:0] best_bid,
    input  logic [31:0] bid_size,
    input  logic [31:0] best_ask,
    input  logic [31:0] ask_size,
    input  logic        book_valid,
    output logic        fill_valid,
    output logic [31:0] fill_qty,
    output logic [31:0] fill_price,
    output logic [7:0]  fill_side,
    output logic        ord_done,
    output logic [1:0]  done_status,
    output logic [31:0] done_filled_qty,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FILL,
        ST_DONE
    } state_t;

    localparam logic [31:0] GAP_LOAD  = 32'(MIN_FILL_GAP - 2);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [31:0] SLICE_MAX = 32'(MAX_SLICE);

    state_t      r_state;
    logic [7:0]  r_side;
    logic [31:0] r_qty;
    logic [31:0] r_price;
    logic [31:0] r_rem;
    logic [31:0] r_filled;
    logic [31:0] r_tmo;
    logic [31:0] r_gap;
    logic        r_ord_ready;
    logic        r_fill_valid;
    logic [31:0] r_fill_qty;
    logic [31:0] r_fill_price;
    logic [7:0]  r_fill_side;
    logic        r_ord_done;
    logic [1:0]  r_done_status;
    logic [31:0] r_done_filled;

    logic        w_buy;
    logic        w_valid_side;
    logic        w_mkt;
    logic [31:0] w_top_px;
    logic [31:0] w_top_sz;
    logic [31:0] w_slice;

    always_comb begin
        w_buy        = (r_side == 8'd1);
        w_valid_side = w_buy || (r_side == 8'd2);
        w_top_px     = w_buy ? best_ask : best_bid;
        w_top_sz     = w_buy ? ask_size : bid_size;
        w_mkt        = book_valid && (w_top_sz != '0) &&
                       (w_buy ? (best_ask <= r_price) : (best_bid >= r_price));
        w_slice = r_rem;
        if (w_top_sz < w_slice) w_slice = w_top_sz;
        if (SLICE_MAX < w_slice) w_slice = SLICE_MAX;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_side        <= '0;
            r_qty         <= '0;
            r_price       <= '0;
            r_rem         <= '0;
            r_filled      <= '0;
            r_tmo         <= '0;
            r_gap         <= '0;
            r_ord_ready   <= 1'b0;
            r_fill_valid  <= 1'b0;
            r_fill_qty    <= '0;
            r_fill_price  <= '0;
            r_fill_side   <= '0;
            r_ord_done    <= 1'b0;
            r_done_status <= '0;
            r_done_filled <= '0;
        end else begin
            r_fill_valid <= 1'b0;
            r_ord_done   <= 1'b0;

            // Spacing counter runs independently of the order FSM so it spans orders.
            if (r_state == ST_FILL) begin
                r_gap <= GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 32'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (ord_valid && r_ord_ready) begin
                        r_side      <= ord_side;
                        r_qty       <= ord_qty;
                        r_price     <= ord_price;
                        r_rem       <= ord_qty;
                        r_filled    <= '0;
                        r_tmo       <= '0;
                        r_ord_ready <= 1'b0;
                        r_state     <= ST_CHECK;
                    end else begin
                        r_ord_ready <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!w_valid_side || (r_qty == '0)) begin
                        r_ord_done    <= 1'b1;
                        r_done_status <= 2'd2;
                        r_done_filled <= r_filled;
                        r_state       <= ST_DONE;
                    end else if (r_rem == '0) begin
                        r_ord_done    <= 1'b1;
                        r_done_status <= 2'd0;
                        r_done_filled <= r_filled;
                        r_state       <= ST_DONE;
                    end else if (r_gap != '0) begin
                        r_state <= ST_CHECK;
                    end else if (w_mkt) begin
                        r_fill_valid <= 1'b1;
                        r_fill_qty   <= w_slice;
                        r_fill_price <= w_top_px;
                        r_fill_side  <= r_side;
                        r_rem        <= r_rem - w_slice;
                        r_filled     <= r_filled + w_slice;
                        r_tmo        <= '0;
                        r_state      <= ST_FILL;
                    end else if (r_tmo == TMO_LAST) begin
                        r_tmo         <= r_tmo + 32'd1;
                        r_ord_done    <= 1'b1;
                        r_done_status <= 2'd1;
                        r_done_filled <= r_filled;
                        r_state       <= ST_DONE;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                ST_FILL: begin
                    if (r_rem == '0) begin
                        r_ord_done    <= 1'b1;
                        r_done_status <= 2'd0;
                        r_done_filled <= r_filled;
                        r_state       <= ST_DONE;
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    r_ord_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ord_ready       = r_ord_ready;
    assign fill_valid      = r_fill_valid;
    assign fill_qty        = r_fill_qty;
    assign fill_price      = r_fill_price;
    assign fill_side       = r_fill_side;
    assign ord_done        = r_ord_done;
    assign done_status     = r_done_status;
    assign done_filled_qty = r_done_filled;
    assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fill_generator.sv
// Bench for fill_generator: table of single-order cases plus hand-written
// multi-cycle sequences, checked against a queue-based scoreboard.
module tb_fill_generator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ord_valid = 1'b0;
    logic        ord_ready;
    logic [7:0]  ord_side = '0;
    logic [31:0] ord_qty = '0;
    logic [31:0] ord_price = '0;
    logic [31:0] best_bid = '0;
    logic [31:0] bid_size = '0;
    logic [31:0] best_ask = '0;
    logic [31:0] ask_size = '0;
    logic        book_valid = 1'b0;
    logic        fill_valid;
    logic [31:0] fill_qty;
    logic [31:0] fill_price;
    logic [7:0]  fill_side;
    logic        ord_done;
    logic [1:0]  done_status;
    logic [31:0] done_filled_qty;
    logic        busy;

    fill_generator #(.MAX_SLICE(100), .MIN_FILL_GAP(5), .TIMEOUT(64)) dut (
        .clk(clk), .rstn(rstn), .ord_valid(ord_valid), .ord_ready(ord_ready),
        .ord_side(ord_side), .ord_qty(ord_qty), .ord_price(ord_price),
        .best_bid(best_bid), .bid_size(bid_size), .best_ask(best_ask), .ask_size(ask_size),
        .book_valid(book_valid), .fill_valid(fill_valid), .fill_qty(fill_qty),
        .fill_price(fill_price), .fill_side(fill_side), .ord_done(ord_done),
        .done_status(done_status), .done_filled_qty(done_filled_qty), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] qty;
        logic [31:0] price;
        logic [7:0]  side;
        int          at;
    } fill_exp_t;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] filled;
        int          at;
    } done_exp_t;

    typedef struct {
        logic [7:0]  side;
        logic [31:0] qty;
        logic [31:0] price;
        logic        bv;
        logic [31:0] bid;
        logic [31:0] bsz;
        logic [31:0] ask;
        logic [31:0] asz;
        logic [1:0]  st;
        logic [31:0] filled;
        int          lat;
    } vec_t;

    fill_exp_t fq[$];
    done_exp_t dq[$];
    fill_exp_t fe;
    done_exp_t de;
    int last_fill = -1000;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (fill_valid) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fill: got qty %0d at cycle %0d expected none", fill_qty, cyc);
            end else begin
                fe = fq.pop_front();
                chk("fill_qty", fill_qty, fe.qty);
                chk("fill_price", fill_price, fe.price);
                chk("fill_side", fill_side, fe.side);
                chk("fill_cycle", cyc, fe.at);
            end
            checks++;
            if (cyc - last_fill < 5) begin
                errors++;
                $display("FAIL fill_spacing: got %0d expected >= 5", cyc - last_fill);
            end
            last_fill = cyc;
        end
        if (ord_done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got status %0d at cycle %0d expected none", done_status, cyc);
            end else begin
                de = dq.pop_front();
                chk("done_status", done_status, de.status);
                chk("done_filled", done_filled_qty, de.filled);
                chk("done_cycle", cyc, de.at);
            end
        end
    end

    // Waits for ord_ready with ord_valid high; hs is the handshake cycle.
    // Returns on the following negedge with ord_valid still asserted.
    task automatic drive_order(input logic [7:0] s, input logic [31:0] q,
                               input logic [31:0] p, output int hs);
        int n;
        ord_side  = s;
        ord_qty   = q;
        ord_price = p;
        ord_valid = 1'b1;
        hs = -1;
        for (n = 0; n < 200; n++) begin
            if (ord_ready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        if (hs < 0) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no ord_ready expected within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic set_book(input logic bv, input logic [31:0] bid, input logic [31:0] bsz,
                            input logic [31:0] ask, input logic [31:0] asz);
        book_valid = bv;
        best_bid   = bid;
        bid_size   = bsz;
        best_ask   = ask;
        ask_size   = asz;
    endtask

    // Reference model for a static book: which slices, at which cycles.
    task automatic push_fills(input vec_t v, input int hs);
        logic [31:0] rem, sz, px, sl;
        bit mkt;
        int k;
        if (!(v.side == 8'd1 || v.side == 8'd2) || v.qty == 0) return;
        sz  = (v.side == 8'd1) ? v.asz : v.bsz;
        px  = (v.side == 8'd1) ? v.ask : v.bid;
        mkt = v.bv && (sz != 0) && ((v.side == 8'd1) ? (v.ask <= v.price) : (v.bid >= v.price));
        if (!mkt) return;
        rem = v.qty;
        k = 0;
        while (rem != 0) begin
            sl = rem;
            if (sz < sl) sl = sz;
            if (32'd100 < sl) sl = 32'd100;
            fq.push_back('{sl, px, v.side, hs + 2 + 5 * k});
            rem -= sl;
            k++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            if (fq.size() == 0 && dq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", fq.size() + dq.size(), 0);
        repeat (8) @(negedge clk);
    endtask

    vec_t tbl[7];
    vec_t v;
    int hs, hs_b;

    initial begin
        tbl[0] = '{8'd1, 32'd250, 32'd1000, 1'b1, 32'd0,    32'd0,   32'd999,  32'd1000, 2'd0, 32'd250, 13};
        tbl[1] = '{8'd2, 32'd40,  32'd1000, 1'b1, 32'd990,  32'd500, 32'd0,    32'd0,    2'd1, 32'd0,   65};
        tbl[2] = '{8'd3, 32'd10,  32'd1000, 1'b1, 32'd1000, 32'd500, 32'd999,  32'd500,  2'd2, 32'd0,   2};
        tbl[3] = '{8'd1, 32'd0,   32'd1000, 1'b1, 32'd1000, 32'd500, 32'd999,  32'd500,  2'd2, 32'd0,   2};
        tbl[4] = '{8'd2, 32'd150, 32'd1000, 1'b1, 32'd1000, 32'd70,  32'd0,    32'd0,    2'd0, 32'd150, 13};
        tbl[5] = '{8'd1, 32'd30,  32'd1000, 1'b0, 32'd0,    32'd0,   32'd1000, 32'd30,   2'd1, 32'd0,   65};
        tbl[6] = '{8'd1, 32'd100, 32'd1000, 1'b1, 32'd0,    32'd0,   32'd1000, 32'd500,  2'd0, 32'd100, 3};

        repeat (3) @(negedge clk);
        chk("rst_ord_ready", ord_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_ord_done", ord_done, 0);
        chk("rst_fill_qty", fill_qty, 0);
        chk("rst_done_filled", done_filled_qty, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ord_ready, 1);

        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            set_book(v.bv, v.bid, v.bsz, v.ask, v.asz);
            drive_order(v.side, v.qty, v.price, hs);
            ord_valid = 1'b0;
            push_fills(v, hs);
            dq.push_back('{v.st, v.filled, hs + v.lat});
            wait_drain(200);
        end

        // Top size vanishes after the first slice: one fill, then expiry.
        set_book(1'b1, 32'd0, 32'd0, 32'd999, 32'd100);
        drive_order(8'd1, 32'd300, 32'd1000, hs);
        ord_valid = 1'b0;
        fq.push_back('{32'd100, 32'd999, 8'd1, hs + 2});
        dq.push_back('{2'd1, 32'd100, hs + 70});
        while (cyc < hs + 2) @(negedge clk);
        ask_size = '0;
        wait_drain(200);

        // Back-to-back orders: second fill still respects spacing.
        set_book(1'b1, 32'd1005, 32'd1000, 32'd999, 32'd1000);
        drive_order(8'd1, 32'd50, 32'd1000, hs);
        fq.push_back('{32'd50, 32'd999, 8'd1, hs + 2});
        dq.push_back('{2'd0, 32'd50, hs + 3});
        drive_order(8'd2, 32'd20, 32'd1000, hs_b);
        ord_valid = 1'b0;
        chk("b_handshake_cycle", hs_b, hs + 4);
        fq.push_back('{32'd20, 32'd1005, 8'd2, hs + 7});
        dq.push_back('{2'd0, 32'd20, hs + 8});
        wait_drain(200);

        // Reset between fills abandons the order silently.
        set_book(1'b1, 32'd0, 32'd0, 32'd999, 32'd1000);
        drive_order(8'd1, 32'd250, 32'd1000, hs);
        ord_valid = 1'b0;
        fq.push_back('{32'd100, 32'd999, 8'd1, hs + 2});
        while (cyc < hs + 4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", ord_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_fill_qty", fill_qty, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_after", ord_ready, 1);
        repeat (20) @(negedge clk);
        chk("mid_rst_fill_consumed", fq.size(), 0);
        v = '{8'd1, 32'd120, 32'd1000, 1'b1, 32'd0, 32'd0, 32'd999, 32'd1000, 2'd0, 32'd120, 8};
        drive_order(v.side, v.qty, v.price, hs);
        ord_valid = 1'b0;
        push_fills(v, hs);
        dq.push_back('{v.st, v.filled, hs + v.lat});
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
